fetch_stage: RTL and testbench

Instruction-fetch stage of the RV32I pipelined processor. Owns the program counter, issues word requests to instruction memory over a req/ack handshake, and drives the PC/instruction pair consumed by the IF/ID pipeline register. Handles stall back-pressure from the hazard unit and PC redirects (branch/jump) from execute, including discarding responses to abandoned requests.

---
 rtl/fetch_stage_pkg.sv | 24 ++
 rtl/fetch_stage_if.sv | 22 ++
 rtl/fetch_stage.sv | 148 ++++++++++++++
 tb/tb_fetch_stage.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared constants for the RV32I instruction-fetch stage: NOP encoding,
// default reset PC, fetch FSM encoding and small PC helper functions.
package fetch_stage_pkg;

  // addi x0, x0, 0 -- placed on the output whenever no real instruction is held
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // Fetch FSM encoding; 2'b11 is unused and recovers to FETCH
  localparam logic [1:0] ST_FETCH = 2'd0;
  localparam logic [1:0] ST_HOLD  = 2'd1;
  localparam logic [1:0] ST_DROP  = 2'd2;

  // Force a byte address onto a word boundary
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

  // Sequential next PC; wraps naturally modulo 2^32
  function automatic logic [31:0] pc_next(input logic [31:0] addr);
    return addr + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/acknowledge bus between the fetch stage
// (master) and instruction memory (slave).
interface fetch_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_stage.sv
// RV32I instruction-fetch stage. Owns the PC, requests words from
// instruction memory, and presents a registered PC/instruction pair to
// the IF/ID register. A one-entry skid buffer absorbs a response that
// lands while the pipeline is stalled; DROP swallows the response to a
// request abandoned by a redirect so memory sees a stable address.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall,
  input  logic                 redirect_en,
  input  logic [31:0]          redirect_pc,
  fetch_stage_if.master        imem,
  output logic [31:0]          pre_address_pc,
  output logic [31:0]          instruction_fetch,
  output logic                 fetch_valid
);

  logic [1:0]  state_r;
  logic [31:0] pc_r;
  logic [31:0] drop_addr_r;
  logic [31:0] skid_instr_r;
  logic [31:0] skid_pc_r;

  logic        req_s;
  logic [31:0] addr_s;
  logic [31:0] redirect_target_s;
  logic [31:0] pc_inc_s;

  assign redirect_target_s = word_align(redirect_pc);
  assign pc_inc_s          = pc_next(pc_r);

  // Request valid/address decode from the FSM state
  always_comb begin
    req_s  = 1'b0;
    addr_s = pc_r;
    case (state_r)
      ST_FETCH: begin
        req_s  = 1'b1;
        addr_s = pc_r;
      end
      ST_DROP: begin
        req_s  = 1'b1;
        addr_s = drop_addr_r;
      end
      ST_HOLD: begin
        req_s  = 1'b0;
        addr_s = pc_r;
      end
      default: begin
        req_s  = 1'b0;
        addr_s = pc_r;
      end
    endcase
  end

  // Reset kills an in-flight request immediately, not at the next edge
  assign imem.imem_req  = req_s & ~rst;
  assign imem.imem_addr = addr_s;

  // PC, FSM, skid buffer and registered IF/ID outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r           <= ST_FETCH;
      pc_r              <= RESET_PC;
      drop_addr_r       <= 32'h0000_0000;
      skid_instr_r      <= 32'h0000_0000;
      skid_pc_r         <= 32'h0000_0000;
      pre_address_pc    <= RESET_PC;
      instruction_fetch <= NOP_INSTR;
      fetch_valid       <= 1'b0;
    end else begin
      case (state_r)
        ST_FETCH: begin
          if (redirect_en) begin
            // Redirect wins over stall; any response this cycle is stale
            pc_r              <= redirect_target_s;
            fetch_valid       <= 1'b0;
            instruction_fetch <= NOP_INSTR;
            skid_instr_r      <= 32'h0000_0000;
            skid_pc_r         <= 32'h0000_0000;
            if (!imem.imem_ack) begin
              // Outstanding request must still complete at its old address
              drop_addr_r <= pc_r;
              state_r     <= ST_DROP;
            end else begin
              state_r <= ST_FETCH;
            end
          end else if (imem.imem_ack) begin
            pc_r <= pc_inc_s;
            if (!stall) begin
              pre_address_pc    <= pc_r;
              instruction_fetch <= imem.imem_rdata;
              fetch_valid       <= 1'b1;
            end else begin
              // Downstream busy: park the response until the stall clears
              skid_pc_r    <= pc_r;
              skid_instr_r <= imem.imem_rdata;
              state_r      <= ST_HOLD;
            end
          end else if (!stall) begin
            fetch_valid       <= 1'b0;
            instruction_fetch <= NOP_INSTR;
          end else begin
            state_r <= ST_FETCH;
          end
        end
        ST_HOLD: begin
          if (redirect_en) begin
            pc_r              <= redirect_target_s;
            fetch_valid       <= 1'b0;
            instruction_fetch <= NOP_INSTR;
            skid_instr_r      <= 32'h0000_0000;
            skid_pc_r         <= 32'h0000_0000;
            state_r           <= ST_FETCH;
          end else if (!stall) begin
            pre_address_pc    <= skid_pc_r;
            instruction_fetch <= skid_instr_r;
            fetch_valid       <= 1'b1;
            state_r           <= ST_FETCH;
          end else begin
            state_r <= ST_HOLD;
          end
        end
        ST_DROP: begin
          if (redirect_en) begin
            // Abandoned request still pending; only retarget the PC
            pc_r              <= redirect_target_s;
            fetch_valid       <= 1'b0;
            instruction_fetch <= NOP_INSTR;
            state_r           <= ST_DROP;
          end else if (imem.imem_ack) begin
            state_r <= ST_FETCH;
          end else begin
            state_r <= ST_DROP;
          end
        end
        default: begin
          state_r <= ST_FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage. A behavioural instruction
// memory with programmable ack latency returns instr_of(addr); expected
// PC/instruction pairs are queued as stimulus is driven and popped each
// time the stage presents a new valid instruction.
module tb_fetch_stage;
  import fetch_stage_pkg::*;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } item_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        redirect_en = 1'b0;
  logic [31:0] redirect_pc = 32'h0000_0000;
  logic [31:0] pre_address_pc;
  logic [31:0] instruction_fetch;
  logic        fetch_valid;

  int checks = 0;
  int failures = 0;
  int lat = 0;
  int wcnt;

  item_t exp_q[$];
  item_t last_out = '0;

  logic        p_stall, p_redir, p_req, p_ack;
  logic [31:0] p_addr;

  fetch_stage_if bus();

  fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk               (clk),
    .rst               (rst),
    .stall             (stall),
    .redirect_en       (redirect_en),
    .redirect_pc       (redirect_pc),
    .imem              (bus),
    .pre_address_pc    (pre_address_pc),
    .instruction_fetch (instruction_fetch),
    .fetch_valid       (fetch_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  // Memory model: ack once the request has waited lat cycles
  assign bus.imem_ack   = bus.imem_req && (wcnt >= lat);
  assign bus.imem_rdata = bus.imem_ack ? instr_of(bus.imem_addr) : 32'hDEAD_BEEF;

  // Wait-cycle counter of the memory model
  always @(posedge clk or posedge rst) begin
    if (rst) wcnt <= 0;
    else if (bus.imem_req && !bus.imem_ack) wcnt <= wcnt + 1;
    else wcnt <= 0;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic push(input logic [31:0] pc);
    item_t it;
    it.pc    = pc;
    it.instr = instr_of(pc);
    exp_q.push_back(it);
  endtask

  // One clock: snapshot pre-edge inputs, advance, check outputs at negedge
  task automatic tick(input string tag, input logic ev);
    item_t it;
    #1;
    p_stall = stall;
    p_redir = redirect_en;
    p_req   = bus.imem_req;
    p_ack   = bus.imem_ack;
    p_addr  = bus.imem_addr;
    @(posedge clk);
    @(negedge clk);
    chk({tag, "/valid"}, {31'd0, fetch_valid}, {31'd0, ev});
    if (!ev) begin
      chk({tag, "/nop"}, instruction_fetch, NOP_INSTR);
    end else if (p_stall && !p_redir) begin
      chk({tag, "/hold_pc"}, pre_address_pc, last_out.pc);
      chk({tag, "/hold_instr"}, instruction_fetch, last_out.instr);
    end else begin
      checks++;
      assert (exp_q.size() > 0) else begin
        failures++;
        $error("FAIL %s/underflow observed=empty expected=queued_item", tag);
      end
      if (exp_q.size() > 0) begin
        it = exp_q.pop_front();
        chk({tag, "/pc"}, pre_address_pc, it.pc);
        chk({tag, "/instr"}, instruction_fetch, it.instr);
        last_out = it;
      end
    end
    if (p_req && !p_ack) begin
      chk({tag, "/req_held"}, {31'd0, bus.imem_req}, 32'd1);
      chk({tag, "/addr_stable"}, bus.imem_addr, p_addr);
    end
  endtask

  initial begin
    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_req", {31'd0, bus.imem_req}, 32'd0);
    chk("rst_valid", {31'd0, fetch_valid}, 32'd0);
    chk("rst_instr", instruction_fetch, NOP_INSTR);
    chk("rst_pc", pre_address_pc, 32'h0000_0000);
    rst = 1'b0;

    // Zero-wait memory: one instruction per cycle from PC 0
    for (int i = 0; i < 8; i++) begin
      push(32'(i * 4));
      tick("zw", 1'b1);
    end

    // Two-cycle latency: valid pattern 0,0,1
    lat = 2;
    tick("lat2_a", 1'b0);
    tick("lat2_b", 1'b0);
    push(32'h0000_0020);
    tick("lat2_c", 1'b1);
    tick("lat2_d", 1'b0);
    tick("lat2_e", 1'b0);
    push(32'h0000_0024);
    tick("lat2_f", 1'b1);

    // Stall while a response arrives: skid then release
    lat = 0;
    push(32'h0000_0028);
    tick("pre_stall", 1'b1);
    stall = 1'b1;
    tick("stall1", 1'b1);
    chk("hold_req", {31'd0, bus.imem_req}, 32'd0);
    tick("stall2", 1'b1);
    tick("stall3", 1'b1);
    stall = 1'b0;
    push(32'h0000_002C);
    tick("release", 1'b1);
    push(32'h0000_0030);
    tick("after_release", 1'b1);

    // Redirect while a request is outstanding: old address held, data dropped
    lat = 3;
    tick("wait_0x34", 1'b0);
    redirect_en = 1'b1;
    redirect_pc = 32'h0000_0103;
    tick("redir_drop", 1'b0);
    redirect_en = 1'b0;
    chk("drop_req", {31'd0, bus.imem_req}, 32'd1);
    chk("drop_addr", bus.imem_addr, 32'h0000_0034);
    tick("drop_wait", 1'b0);
    tick("drop_ack", 1'b0);
    chk("redir_addr", bus.imem_addr, 32'h0000_0100);
    lat = 0;
    push(32'h0000_0100);
    tick("tgt0", 1'b1);
    push(32'h0000_0104);
    tick("tgt1", 1'b1);

    // Redirect together with stall in HOLD: skid discarded, then PC wrap
    stall = 1'b1;
    tick("hold_in", 1'b1);
    redirect_en = 1'b1;
    redirect_pc = 32'hFFFF_FFFE;
    tick("hold_redir", 1'b0);
    redirect_en = 1'b0;
    tick("wrap_skid", 1'b0);
    stall = 1'b0;
    push(32'hFFFF_FFFC);
    tick("wrap_top", 1'b1);
    push(32'h0000_0000);
    tick("wrap_zero", 1'b1);

    // Redirect coinciding with an ack in FETCH
    redirect_en = 1'b1;
    redirect_pc = 32'h0000_0200;
    tick("redir_ack", 1'b0);
    redirect_en = 1'b0;
    push(32'h0000_0200);
    tick("redir_ack_tgt", 1'b1);

    // Reset asserted mid-request drops the request at once
    lat = 3;
    tick("pre_rst_wait", 1'b0);
    rst = 1'b1;
    #1;
    chk("midrst_req", {31'd0, bus.imem_req}, 32'd0);
    chk("midrst_valid", {31'd0, fetch_valid}, 32'd0);
    chk("midrst_pc", pre_address_pc, 32'h0000_0000);
    chk("midrst_instr", instruction_fetch, NOP_INSTR);
    @(negedge clk);
    rst = 1'b0;
    lat = 0;
    push(32'h0000_0000);
    tick("post_rst0", 1'b1);
    push(32'h0000_0004);
    tick("post_rst1", 1'b1);

    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
